// File: rtl/mandel_result_writer.sv
// Collects per-pixel iteration counts and writes them to the DDR iteration frame buffer
// as MCB write bursts. Optional idle flush of partial bursts: define MANDEL_WR_TIMEOUT_EN.
module mandel_result_writer #(
   parameter logic [29:0] BASE_ADDR      = 30'd0,
   parameter int          BURST_LEN      = 64,
   parameter int          TIMEOUT_CYCLES = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [20:0] i_total_pixels,
   input  logic        i_res_valid,
   input  logic [31:0] i_res_iter,
   output logic        o_res_ready,
   output logic        o_frame_done,
   input  logic        i_mem_calib_done,
   input  logic        i_wr_full,
   input  logic        i_wr_empty,
   output logic        o_wr_en,
   output logic [31:0] o_wr_data,
   input  logic        i_cmd_full,
   output logic        o_cmd_en,
   output logic [2:0]  o_cmd_instr,
   output logic [5:0]  o_cmd_bl,
   output logic [29:0] o_cmd_byte_addr,
   output logic [1:0]  o_dbg_state
);

   // Result handshake: a word moves when i_res_valid and o_res_ready are both high at
   // the rising edge; the same cycle pushes it into the MCB write FIFO via o_wr_en.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_CMD   = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   localparam logic [6:0] LP_BURST_LEN = 7'(BURST_LEN);

   state_t      r_state;
   state_t      w_next_state;
   logic        r_calib_meta;
   logic        r_calib_sync;
   logic [20:0] r_frame_px;
   logic [20:0] r_pixel_index;
   logic [20:0] r_burst_start;
   logic [6:0]  r_burst_cnt;
   logic        r_cmd_en;
   logic        r_frame_done;
   logic [5:0]  r_cmd_bl;
   logic [29:0] r_cmd_byte_addr;

   logic [20:0] w_remain;
   logic [6:0]  w_limit;
   logic        w_accept;
   logic        w_timeout;
   logic        w_frame_end;

   // The last burst of a frame is shortened to the pixels that remain.
   assign w_remain    = r_frame_px - r_burst_start;
   assign w_limit     = (w_remain >= 21'(BURST_LEN)) ? LP_BURST_LEN : w_remain[6:0];
   assign w_accept    = i_res_valid & o_res_ready;
   assign w_frame_end = (r_pixel_index == r_frame_px);

`ifdef MANDEL_WR_TIMEOUT_EN
   localparam int                   LP_IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [LP_IDLE_W-1:0] LP_IDLE_MAX = LP_IDLE_W'(TIMEOUT_CYCLES);

   logic [LP_IDLE_W-1:0] r_idle_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_idle_cnt <= '0;
      end else if (r_state != S_FILL || w_accept) begin
         r_idle_cnt <= '0;
      end else if (r_burst_cnt != 7'd0 && !w_timeout) begin
         r_idle_cnt <= r_idle_cnt + LP_IDLE_W'(1);
      end
   end

   assign w_timeout = (r_state == S_FILL) && (r_idle_cnt == LP_IDLE_MAX);
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (r_calib_sync) w_next_state = S_FILL;
         S_FILL:  if (r_burst_cnt == w_limit || w_timeout) w_next_state = S_CMD;
         S_CMD:   if (!i_cmd_full) w_next_state = S_DRAIN;
         S_DRAIN: if (i_wr_empty) w_next_state = S_FILL;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      o_res_ready = (r_state == S_FILL) && !i_wr_full && (r_burst_cnt < w_limit) && !w_timeout;
      o_wr_en     = i_res_valid && o_res_ready;
      o_wr_data   = i_res_iter;
      o_cmd_instr = 3'b000;
      o_dbg_state = r_state;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_calib_meta <= 1'b0;
         r_calib_sync <= 1'b0;
      end else begin
         r_calib_meta <= i_mem_calib_done;
         r_calib_sync <= r_calib_meta;
      end
   end

   // Burst bookkeeping and the registered command interface.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_frame_px      <= '0;
         r_pixel_index   <= '0;
         r_burst_start   <= '0;
         r_burst_cnt     <= '0;
         r_cmd_en        <= 1'b0;
         r_frame_done    <= 1'b0;
         r_cmd_bl        <= '0;
         r_cmd_byte_addr <= '0;
      end else begin
         r_cmd_en     <= 1'b0;
         r_frame_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (r_calib_sync) r_frame_px <= i_total_pixels;
            end
            S_FILL: begin
               if (w_accept) begin
                  r_burst_cnt   <= r_burst_cnt + 7'd1;
                  r_pixel_index <= r_pixel_index + 21'd1;
               end
            end
            S_CMD: begin
               if (!i_cmd_full) begin
                  r_cmd_en        <= 1'b1;
                  r_cmd_bl        <= 6'(r_burst_cnt - 7'd1);
                  r_cmd_byte_addr <= BASE_ADDR + {7'd0, r_burst_start, 2'b00};
               end
            end
            S_DRAIN: begin
               if (i_wr_empty) begin
                  r_burst_cnt <= '0;
                  if (w_frame_end) begin
                     // Next frame restarts at pixel 0 with a freshly sampled size.
                     r_pixel_index <= '0;
                     r_burst_start <= '0;
                     r_frame_px    <= i_total_pixels;
                     r_frame_done  <= 1'b1;
                  end else begin
                     r_burst_start <= r_pixel_index;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign o_cmd_en        = r_cmd_en;
   assign o_frame_done    = r_frame_done;
   assign o_cmd_bl        = r_cmd_bl;
   assign o_cmd_byte_addr = r_cmd_byte_addr;

endmodule

// File: tb/tb_mandel_result_writer.sv
// Self-checking bench for mandel_result_writer: randomized results, a small MCB model,
// and expected command/data queues derived from frame size and burst length.
module tb_mandel_result_writer;

   localparam logic [29:0] BASE = 30'h3FFF_FF00;
   localparam int          BL   = 64;

   logic        clk;
   logic        reset;
   logic [20:0] total_pixels;
   logic        res_valid;
   logic [31:0] res_iter;
   logic        res_ready;
   logic        frame_done;
   logic        mem_calib_done;
   logic        wr_full;
   logic        wr_empty = 1'b1;
   logic        wr_en;
   logic [31:0] wr_data;
   logic        cmd_full;
   logic        cmd_en;
   logic [2:0]  cmd_instr;
   logic [5:0]  cmd_bl;
   logic [29:0] cmd_byte_addr;
   logic [1:0]  dbg_state;

   int checks = 0;
   int errors = 0;

   logic [38:0] exp_cmd_q[$];
   logic [38:0] obs_cmd_q[$];
   logic [31:0] exp_data_q[$];
   logic [31:0] obs_data_q[$];
   int fd_cnt     = 0;
   int fifo_cnt   = 0;
   int drain_pend = 0;
   int drain_wait = 0;

   mandel_result_writer #(.BASE_ADDR(BASE), .BURST_LEN(BL), .TIMEOUT_CYCLES(256)) dut (
      .clk(clk), .reset(reset), .i_total_pixels(total_pixels),
      .i_res_valid(res_valid), .i_res_iter(res_iter), .o_res_ready(res_ready),
      .o_frame_done(frame_done), .i_mem_calib_done(mem_calib_done),
      .i_wr_full(wr_full), .i_wr_empty(wr_empty), .o_wr_en(wr_en), .o_wr_data(wr_data),
      .i_cmd_full(cmd_full), .o_cmd_en(cmd_en), .o_cmd_instr(cmd_instr),
      .o_cmd_bl(cmd_bl), .o_cmd_byte_addr(cmd_byte_addr), .o_dbg_state(dbg_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Observer plus MCB model: words leave the FIFO only after a command asks for them.
   always @(negedge clk) begin
      if (reset) begin
         fifo_cnt = 0; drain_pend = 0; drain_wait = 0; wr_empty = 1'b1;
      end else begin
         if (wr_en) begin
            obs_data_q.push_back(wr_data);
            fifo_cnt++;
         end
         if (cmd_en) begin
            obs_cmd_q.push_back({cmd_instr, cmd_bl, cmd_byte_addr});
            drain_pend += cmd_bl + 1;
            drain_wait = $urandom_range(4, 1);
         end else if (drain_wait > 0) begin
            drain_wait--;
         end else if (drain_pend > 0 && fifo_cnt > 0) begin
            fifo_cnt--;
            drain_pend--;
         end
         if (frame_done) fd_cnt++;
         wr_empty = (fifo_cnt == 0);
      end
   end

   // Reference model: one write command covering pixels [start, start+len).
   task automatic model_cmd(input int start, input int len);
      exp_cmd_q.push_back({3'b000, 6'(len - 1), 30'(BASE + 4 * start)});
   endtask

   task automatic model_frame(input int n);
      for (int s = 0; s < n; s += BL) begin
         model_cmd(s, (n - s < BL) ? n - s : BL);
      end
   endtask

   task automatic apply_reset(input bit calib);
      reset = 1'b1; res_valid = 1'b0; res_iter = '0;
      wr_full = 1'b0; cmd_full = 1'b0; mem_calib_done = calib;
      repeat (2) @(posedge clk);
      #2;
      exp_cmd_q.delete(); obs_cmd_q.delete(); exp_data_q.delete(); obs_data_q.delete();
      fd_cnt = 0;
      reset = 1'b0;
   endtask

   task automatic send(input int n, input int max_gap, input int stall_at, input int stall_len,
                       output bit ok, output int stall_bad);
      int  tmo;
      bit  acc;
      ok = 1'b1; stall_bad = 0;
      for (int i = 0; i < n && ok; i++) begin
         if (max_gap > 0) begin
            res_valid = 1'b0;
            repeat ($urandom_range(max_gap, 0)) begin @(posedge clk); #2; end
         end
         res_valid = 1'b1;
         res_iter  = $urandom;
         if (i == stall_at) begin
            wr_full = 1'b1;
            repeat (stall_len) begin
               @(negedge clk);
               if (res_ready !== 1'b0 || wr_en !== 1'b0) stall_bad++;
               @(posedge clk); #2;
            end
            wr_full = 1'b0;
         end
         tmo = 0; acc = 1'b0;
         while (!acc && tmo < 1000) begin
            @(negedge clk);
            acc = res_ready;
            @(posedge clk); #2;
            tmo++;
         end
         if (acc) exp_data_q.push_back(res_iter);
         else ok = 1'b0;
      end
      res_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(posedge clk); #2;
         if (obs_cmd_q.size() >= exp_cmd_q.size() && fifo_cnt == 0 && drain_pend == 0) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (8) @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      bit ok; int sb;
      total_pixels = 21'd128;
      apply_reset(1'b1);
      send(5, 0, -1, 0, ok, sb);
      res_valid = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL rst_async_ready: got %b want 0", res_ready); end
      @(negedge clk);
      checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b want 0", wr_en); end
      checks++; if (cmd_en !== 1'b0) begin errors++; $display("FAIL rst_cmd_en: got %b want 0", cmd_en); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
      checks++; if (cmd_bl !== 6'd0) begin errors++; $display("FAIL rst_cmd_bl: got %0d want 0", cmd_bl); end
      checks++; if (cmd_byte_addr !== 30'd0) begin errors++; $display("FAIL rst_cmd_addr: got %h want 0", cmd_byte_addr); end
      checks++; if (cmd_instr !== 3'd0) begin errors++; $display("FAIL rst_cmd_instr: got %0d want 0", cmd_instr); end
      res_valid = 1'b0;
      @(posedge clk); #2;
   endtask

   task automatic test_calib();
      int bad; int cyc;
      total_pixels = 21'd128;
      apply_reset(1'b0);
      res_valid = 1'b1; res_iter = $urandom; bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (res_ready !== 1'b0 || wr_en !== 1'b0) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL calib_low_ready: %0d cycles ready, want 0", bad); end
      @(posedge clk); #2;
      res_valid = 1'b0;
      mem_calib_done = 1'b1;
      cyc = 0;
      while (cyc < 10) begin
         @(posedge clk); cyc++;
         @(negedge clk);
         if (res_ready === 1'b1) break;
      end
      checks++; if (cyc > 3 || res_ready !== 1'b1) begin errors++; $display("FAIL calib_rise_latency: ready after %0d cycles (ready=%b), want <=3", cyc, res_ready); end
      @(posedge clk); #2;
   endtask

   task automatic test_full_frame();
      bit ok; bit ok2; int sb;
      total_pixels = 21'd128;
      apply_reset(1'b1);
      model_frame(128);
      model_cmd(0, 64);
      send(128, 0, -1, 0, ok, sb);
      send(64, 0, -1, 0, ok2, sb);
      wait_done(3000, ok);
      checks++; if ((ok & ok2) !== 1'b1) begin errors++; $display("FAIL t1_done: completed=%b want 1", ok & ok2); end
      checks++; if (obs_cmd_q.size() !== exp_cmd_q.size()) begin errors++; $display("FAIL t1_cmd_count: got %0d want %0d", obs_cmd_q.size(), exp_cmd_q.size()); end
      foreach (exp_cmd_q[i]) if (i < obs_cmd_q.size()) begin
         checks++; if (obs_cmd_q[i] !== exp_cmd_q[i]) begin errors++; $display("FAIL t1_cmd%0d: got %h want %h", i, obs_cmd_q[i], exp_cmd_q[i]); end
      end
      checks++; if (obs_data_q.size() !== exp_data_q.size()) begin errors++; $display("FAIL t1_data_count: got %0d want %0d", obs_data_q.size(), exp_data_q.size()); end
      foreach (exp_data_q[i]) if (i < obs_data_q.size()) begin
         checks++; if (obs_data_q[i] !== exp_data_q[i]) begin errors++; $display("FAIL t1_data%0d: got %h want %h", i, obs_data_q[i], exp_data_q[i]); end
      end
      checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL t1_frame_done: got %0d want 1", fd_cnt); end
   endtask

   task automatic test_short_frame();
      bit ok; bit ok2; bit ok3; int sb;
      total_pixels = 21'd100;
      apply_reset(1'b1);
      model_frame(100);
      model_frame(64);
      send(64, 1, -1, 0, ok, sb);
      total_pixels = 21'd64;
      send(36, 1, -1, 0, ok2, sb);
      send(64, 1, -1, 0, ok3, sb);
      wait_done(3000, ok);
      checks++; if ((ok & ok2 & ok3) !== 1'b1) begin errors++; $display("FAIL t2_done: completed=%b want 1", ok & ok2 & ok3); end
      checks++; if (obs_cmd_q.size() !== exp_cmd_q.size()) begin errors++; $display("FAIL t2_cmd_count: got %0d want %0d", obs_cmd_q.size(), exp_cmd_q.size()); end
      foreach (exp_cmd_q[i]) if (i < obs_cmd_q.size()) begin
         checks++; if (obs_cmd_q[i] !== exp_cmd_q[i]) begin errors++; $display("FAIL t2_cmd%0d: got %h want %h", i, obs_cmd_q[i], exp_cmd_q[i]); end
      end
      checks++; if (obs_data_q.size() !== exp_data_q.size()) begin errors++; $display("FAIL t2_data_count: got %0d want %0d", obs_data_q.size(), exp_data_q.size()); end
      foreach (exp_data_q[i]) if (i < obs_data_q.size()) begin
         checks++; if (obs_data_q[i] !== exp_data_q[i]) begin errors++; $display("FAIL t2_data%0d: got %h want %h", i, obs_data_q[i], exp_data_q[i]); end
      end
      checks++; if (fd_cnt !== 2) begin errors++; $display("FAIL t2_frame_done: got %0d want 2", fd_cnt); end
   endtask

   task automatic test_wr_full();
      bit ok; bit ok2; int sb;
      total_pixels = 21'd128;
      apply_reset(1'b1);
      model_cmd(0, 64);
      send(64, 0, 20, 5, ok, sb);
      wait_done(2000, ok2);
      checks++; if ((ok & ok2) !== 1'b1) begin errors++; $display("FAIL t3_done: completed=%b want 1", ok & ok2); end
      checks++; if (sb !== 0) begin errors++; $display("FAIL t3_stall: %0d stall cycles with ready/wr_en high, want 0", sb); end
      checks++; if (obs_cmd_q.size() !== 1) begin errors++; $display("FAIL t3_cmd_count: got %0d want 1", obs_cmd_q.size()); end
      if (obs_cmd_q.size() > 0) begin
         checks++; if (obs_cmd_q[0] !== exp_cmd_q[0]) begin errors++; $display("FAIL t3_cmd0: got %h want %h", obs_cmd_q[0], exp_cmd_q[0]); end
      end
      checks++; if (obs_data_q.size() !== exp_data_q.size()) begin errors++; $display("FAIL t3_data_count: got %0d want %0d", obs_data_q.size(), exp_data_q.size()); end
      foreach (exp_data_q[i]) if (i < obs_data_q.size()) begin
         checks++; if (obs_data_q[i] !== exp_data_q[i]) begin errors++; $display("FAIL t3_data%0d: got %h want %h", i, obs_data_q[i], exp_data_q[i]); end
      end
   endtask

   task automatic test_cmd_full();
      bit ok; bit ok2; int sb; int bad;
      total_pixels = 21'd128;
      apply_reset(1'b1);
      model_cmd(0, 64);
      cmd_full = 1'b1;
      send(64, 0, -1, 0, ok, sb);
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (cmd_en !== 1'b0 || res_ready !== 1'b0) bad++;
      end
      @(posedge clk); #2;
      checks++; if (bad !== 0 || obs_cmd_q.size() !== 0) begin errors++; $display("FAIL t4_hold: %0d bad cycles, %0d cmds during cmd_full, want 0/0", bad, obs_cmd_q.size()); end
      cmd_full = 1'b0;
      wait_done(2000, ok2);
      repeat (20) @(posedge clk);
      #2;
      checks++; if ((ok & ok2) !== 1'b1) begin errors++; $display("FAIL t4_done: completed=%b want 1", ok & ok2); end
      checks++; if (obs_cmd_q.size() !== 1) begin errors++; $display("FAIL t4_pulses: got %0d cmd cycles want 1", obs_cmd_q.size()); end
      if (obs_cmd_q.size() > 0) begin
         checks++; if (obs_cmd_q[0] !== exp_cmd_q[0]) begin errors++; $display("FAIL t4_cmd0: got %h want %h", obs_cmd_q[0], exp_cmd_q[0]); end
      end
   endtask

   task automatic test_partial_burst();
      bit ok; bit ok2; bit ok3; int sb;
      total_pixels = 21'd128;
      apply_reset(1'b1);
      send(10, 0, -1, 0, ok, sb);
      repeat (200) @(posedge clk);
      #2;
      checks++; if (obs_cmd_q.size() !== 0) begin errors++; $display("FAIL t6_early_cmd: got %0d cmds after 200 idle cycles want 0", obs_cmd_q.size()); end
`ifdef MANDEL_WR_TIMEOUT_EN
      model_cmd(0, 10);
      wait_done(400, ok2);
      checks++; if (obs_cmd_q.size() !== 1) begin errors++; $display("FAIL t6_flush_count: got %0d cmds want 1", obs_cmd_q.size()); end
      model_cmd(10, 64);
      model_cmd(74, 54);
`else
      repeat (200) @(posedge clk);
      @(negedge clk);
      ok2 = 1'b1;
      checks++; if (obs_cmd_q.size() !== 0 || res_ready !== 1'b1) begin errors++; $display("FAIL t6_wait: cmds=%0d ready=%b, want 0 cmds and ready 1", obs_cmd_q.size(), res_ready); end
      @(posedge clk); #2;
      model_frame(128);
`endif
      send(118, 0, -1, 0, ok3, sb);
      wait_done(3000, ok);
      checks++; if ((ok & ok2 & ok3) !== 1'b1) begin errors++; $display("FAIL t6_done: completed=%b want 1", ok & ok2 & ok3); end
      checks++; if (obs_cmd_q.size() !== exp_cmd_q.size()) begin errors++; $display("FAIL t6_cmd_count: got %0d want %0d", obs_cmd_q.size(), exp_cmd_q.size()); end
      foreach (exp_cmd_q[i]) if (i < obs_cmd_q.size()) begin
         checks++; if (obs_cmd_q[i] !== exp_cmd_q[i]) begin errors++; $display("FAIL t6_cmd%0d: got %h want %h", i, obs_cmd_q[i], exp_cmd_q[i]); end
      end
      checks++; if (obs_data_q.size() !== exp_data_q.size()) begin errors++; $display("FAIL t6_data_count: got %0d want %0d", obs_data_q.size(), exp_data_q.size()); end
      foreach (exp_data_q[i]) if (i < obs_data_q.size()) begin
         checks++; if (obs_data_q[i] !== exp_data_q[i]) begin errors++; $display("FAIL t6_data%0d: got %h want %h", i, obs_data_q[i], exp_data_q[i]); end
      end
      checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL t6_frame_done: got %0d want 1", fd_cnt); end
   endtask

   task automatic test_random();
      bit ok; bit ok2; bit ok3; int sb; int n;
      for (int it = 0; it < 3; it++) begin
         n = $urandom_range(200, 65);
         total_pixels = 21'(n);
         apply_reset(1'b1);
         model_frame(n);
         model_frame(n);
         send(n, 2, $urandom_range(n - 1, 0), $urandom_range(4, 1), ok, sb);
         send(n, 2, -1, 0, ok2, sb);
         wait_done(4000, ok3);
         checks++; if ((ok & ok2 & ok3) !== 1'b1) begin errors++; $display("FAIL rnd%0d_done: completed=%b want 1", it, ok & ok2 & ok3); end
         checks++; if (obs_cmd_q.size() !== exp_cmd_q.size()) begin errors++; $display("FAIL rnd%0d_cmd_count: got %0d want %0d", it, obs_cmd_q.size(), exp_cmd_q.size()); end
         foreach (exp_cmd_q[i]) if (i < obs_cmd_q.size()) begin
            checks++; if (obs_cmd_q[i] !== exp_cmd_q[i]) begin errors++; $display("FAIL rnd%0d_cmd%0d: got %h want %h", it, i, obs_cmd_q[i], exp_cmd_q[i]); end
         end
         checks++; if (obs_data_q.size() !== exp_data_q.size()) begin errors++; $display("FAIL rnd%0d_data_count: got %0d want %0d", it, obs_data_q.size(), exp_data_q.size()); end
         foreach (exp_data_q[i]) if (i < obs_data_q.size()) begin
            checks++; if (obs_data_q[i] !== exp_data_q[i]) begin errors++; $display("FAIL rnd%0d_data%0d: got %h want %h", it, i, obs_data_q[i], exp_data_q[i]); end
         end
         checks++; if (fd_cnt !== 2) begin errors++; $display("FAIL rnd%0d_frame_done: got %0d want 2", it, fd_cnt); end
      end
   endtask

   initial begin
      #900000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; res_valid = 1'b0; res_iter = '0; total_pixels = 21'd128;
      wr_full = 1'b0; cmd_full = 1'b0; mem_calib_done = 1'b0;
      @(posedge clk); #2;
      test_reset();
      test_calib();
      test_full_frame();
      test_short_frame();
      test_wr_full();
      test_cmd_full();
      test_partial_burst();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
